ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide engine used by the EX stage for MULT/MULTU/DIV/DIVU-class ops.
- Replaces single-cycle multiply with one iterative radix-2 datapath shared by both ops.
- Adds signed/unsigned division, divide-by-zero handling and annulment.
- Result returns as {hi, lo} for the HILO write path; busy_o feeds EX stallreq.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; must be ≥4 and even.
CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start_i  in  1  request; held high by EX until ready_o seen
op_i  in  1  0 = multiply, 1 = divide
signed_i  in  1  1 = two's-complement operands
opdata1_i  in  DATA_W  multiplicand / dividend
opdata2_i  in  DATA_W  multiplier / divisor
annul_i  in  1  abort current op (flush/exception)
result_o  out  2*DATA_W  mul: product; div: {remainder, quotient}
ready_o  out  1  result_o valid
busy_o  out  1  engine working; EX ORs into stallreq

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, result_o 0, ready_o 0, busy_o 0.
- States: IDLE, ZERO, RUN, DONE.
- IDLE: start_i=1 and annul_i=0 latches op, sign mode and operand magnitudes.
  - Signed negative operands are converted via ~x+1.
  - Operands are frozen after the latch; input changes are ignored.
  - Divide with opdata2_i==0 → ZERO; otherwise → RUN with counter=0.
- RUN: one radix-2 step per cycle; exactly DATA_W steps, then → DONE.
  - Multiply: shift-add; multiplier LSB gates addition of the multiplicand into the upper half.
  - Divide: restoring step. Partial remainder {rem, dividend} shifts left 1; trial subtract of divisor over DATA_W+1 bits; quotient bit = ~borrow; remainder restored on borrow.
- Entry to DONE: sign fix applied once to the final magnitude.
  - Multiply: product negated if sign1^sign2 (signed only).
  - Divide: quotient negated if sign1^sign2; remainder negated if dividend negative.
- ZERO: one cycle, then → DONE with result_o = {opdata1 latched, {DATA_W{1'b1}}}.
- DONE: ready_o=1, result_o held stable; → IDLE when start_i==0. No new op is accepted in DONE.
- Latency: start seen in cycle 0 → ready_o high in cycle DATA_W+1 (RUN path) or cycle 2 (ZERO path).
- busy_o=1 in RUN and ZERO only. ready_o=1 only in DONE. Both are registered.
- annul_i:
  - In any state, next edge → IDLE, ready_o=0, busy_o=0; result_o keeps its last value.
  - annul_i has priority over start_i and over completion in the same cycle.
- Signed DIV of the min value by −1: quotient = min value (wraps), remainder 0. No overflow flag.
- Signed MULT of min×min: product = 2^(2*DATA_W−2), exact.
- Reset asserted mid-operation: immediate IDLE; no partial result is exposed (ready_o low).

Optional Feature:
Macro MULDIV_ZERO_SKIP_EN.
- Defined:
  - Multiply with either operand 0 goes through ZERO and returns all-zero result.
  - Divide with dividend 0 (divisor ≠0) goes through ZERO and returns {0,0}.
  - Both complete in 2 cycles.
- Undefined: these cases take the full DATA_W+1-cycle RUN path with identical result values.

Decomposition:
- Shared package/defines:
  - State encodings MD_IDLE/MD_ZERO/MD_RUN/MD_DONE.
  - op_i encodings MD_OP_MUL/MD_OP_DIV.
  - Divide-by-zero quotient constant.
- Sub-module muldiv_step: purely combinational single-iteration datapath.
  - Inputs: op, partial accumulator, operand.
  - Outputs: next accumulator and quotient bit.
  - The FSM/counter stays in the parent.

Test Plan:
- Unsigned div 100/7, DATA_W=32 → ready_o in cycle 33, result_o = {32'd2, 32'd14}; busy_o high cycles 1–32.
- Signed div −7/2 → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Signed div 0x80000000/0xFFFFFFFF → result_o = {32'h0, 32'h80000000}.
- Signed mul −3×5 → result_o = 64'hFFFFFFFF_FFFFFFF1; unsigned mul 0xFFFFFFFF×2 → 64'h1_FFFFFFFE.
- Div 9/0 → ready_o in cycle 2, result_o = {32'd9, 32'hFFFFFFFF}.
  - With MULDIV_ZERO_SKIP_EN: mul 0×123 → ready_o in cycle 2, result_o = 0.
- Annul at RUN cycle 10 → busy_o 0 next cycle, ready_o never rises.
  - An immediate new start of 20/4 then returns {0, 5} on time.
  - Repeat the check with async rst pulsed mid-RUN.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: state, opcode and divide-by-zero encodings
// shared by the iterative multiply/divide engine.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ZERO = 2'd1,
    MD_RUN  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam logic MD_DZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage request/result bundle for the
// multiply/divide engine (master = EX, slave = engine).
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                op_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                busy_o;

  modport master (
    output start_i, op_i, signed_i,
    output opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, op_i, signed_i,
    input  opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration, shift-add for
// multiply or restoring subtract for divide, on a {hi, lo} accumulator.
module muldiv_step
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                op_i,
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   opnd_i,
  output logic [2*DATA_W-1:0] acc_o,
  output logic                q_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              borrow;

  always_comb begin
    sum    = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, opnd_i};
    trial  = acc_i[2*DATA_W-1:DATA_W-1];
    borrow = trial < {1'b0, opnd_i};
    // no-borrow difference always fits in DATA_W bits
    diff   = trial[DATA_W-1:0] - opnd_i;
    acc_o  = acc_i;
    q_o    = 1'b0;
    if (op_i == MD_OP_MUL) begin
      if (acc_i[0]) begin
        acc_o = {sum, acc_i[DATA_W-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*DATA_W-1:1]};
      end
    end else begin
      q_o   = ~borrow;
      acc_o = {borrow ? trial[DATA_W-1:0] : diff,
               acc_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/DIV engine for EX, result as {hi, lo}.
// Define MULDIV_ZERO_SKIP_EN to short-circuit zero-operand ops.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   md
);

  localparam int W2 = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  localparam logic [W2-1:0]     ONE2 = W2'(1);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     res_q, res_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              op_q, op_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [W2-1:0]     step_acc;
  logic              step_q;
  logic [W2-1:0]     fin;
  logic [DATA_W-1:0] mag1, mag2, quo, rem;
  logic              sneg1, sneg2, zskip;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_comb begin
    sneg1 = md.signed_i & md.opdata1_i[DATA_W-1];
    sneg2 = md.signed_i & md.opdata2_i[DATA_W-1];
    mag1  = sneg1 ? (~md.opdata1_i + ONE) : md.opdata1_i;
    mag2  = sneg2 ? (~md.opdata2_i + ONE) : md.opdata2_i;
`ifdef MULDIV_ZERO_SKIP_EN
    zskip = (md.op_i == MD_OP_MUL)
          ? (md.opdata1_i == '0 || md.opdata2_i == '0)
          : (md.opdata1_i == '0);
`else
    zskip = 1'b0;
`endif
    fin = {step_acc[W2-1:1], step_acc[0] | step_q};
    quo = fin[DATA_W-1:0];
    rem = fin[W2-1:DATA_W];
    if (neg1_q ^ neg2_q) quo = ~quo + ONE;
    if (neg1_q) rem = ~rem + ONE;

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;

    unique case (state_q)
      MD_IDLE: begin
        if (md.start_i) begin
          op_d   = md.op_i;
          neg1_d = sneg1;
          neg2_d = sneg2;
          cnt_d  = '0;
          if (md.op_i == MD_OP_DIV) begin
            opnd_d = mag2;
            acc_d  = {{DATA_W{1'b0}}, mag1};
          end else begin
            opnd_d = mag1;
            acc_d  = {{DATA_W{1'b0}}, mag2};
          end
          if (md.op_i == MD_OP_DIV && md.opdata2_i == '0) begin
            state_d = MD_ZERO;
            acc_d   = {md.opdata1_i, {DATA_W{MD_DZ_QUOT_BIT}}};
          end else if (zskip) begin
            state_d = MD_ZERO;
            acc_d   = '0;
          end else begin
            state_d = MD_RUN;
          end
        end
      end
      MD_ZERO: begin
        state_d = MD_DONE;
        res_d   = acc_q;
      end
      MD_RUN: begin
        acc_d = fin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = MD_DONE;
          if (op_q == MD_OP_DIV) begin
            res_d = {rem, quo};
          end else begin
            res_d = (neg1_q ^ neg2_q) ? (~fin + ONE2) : fin;
          end
        end
      end
      MD_DONE: begin
        if (!md.start_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    // abort wins over a fresh start and over completion
    if (md.annul_i) begin
      state_d = MD_IDLE;
      res_d   = res_q;
    end

    ready_d = (state_d == MD_DONE);
    busy_d  = (state_d == MD_RUN) || (state_d == MD_ZERO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign md.result_o = res_q;
  assign md.ready_o  = ready_q;
  assign md.busy_o   = busy_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table plus scoreboard for ex_muldiv_unit,
// with annul and mid-run reset sequences.
module tb_ex_muldiv_unit;

  localparam int W    = 32;
  localparam int FULL = W + 1;
`ifdef MULDIV_ZERO_SKIP_EN
  localparam int SKIP = 2;
`else
  localparam int SKIP = FULL;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.DATA_W(W)) md ();

  ex_muldiv_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  typedef struct {
    logic        op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic op, input logic sgn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int     q, r;
    if (op == 1'b0) begin
      if (sgn) begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Caller must be at a negedge; inputs are driven immediately.
  task automatic run_op(input string nm, input logic op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   busy_bad;
    md.start_i   = 1'b1;
    md.op_i      = op;
    md.signed_i  = sgn;
    md.opdata1_i = a;
    md.opdata2_i = b;
    e.res = exp;
    e.lat = lat;
    sb.push_back(e);
    cyc = 0;
    seen = 0;
    busy_bad = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (md.ready_o) seen = 1;
      else if (md.busy_o !== 1'b1) busy_bad = 1;
      md.opdata1_i = $urandom;
      md.opdata2_i = $urandom;
      md.signed_i  = 1'($urandom);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no ready_o after %0d cycles", nm, cyc);
      e = sb.pop_back();
      md.start_i = 1'b0;
      @(negedge clk);
      return;
    end
    e = sb.pop_front();
    check({nm, " result"}, {1'b0, md.result_o}, {1'b0, e.res});
    check({nm, " latency"}, 65'(cyc), 65'(e.lat));
    check({nm, " busy"}, {64'(busy_bad), md.busy_o}, 65'd0);
    @(negedge clk);
    check({nm, " hold"}, {md.ready_o, md.result_o}, {1'b1, e.res});
    md.start_i = 1'b0;
    @(negedge clk);
    check({nm, " release"}, {64'd0, md.ready_o}, 65'd0);
  endtask

  initial begin
    logic        rop, rsg;
    logic [31:0] ra, rb;
    bit          zc;

    tbl[0]  = '{1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, FULL};
    tbl[1]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,
                {32'hFFFFFFFF, 32'hFFFFFFFD}, FULL};
    tbl[2]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF,
                {32'h0, 32'h80000000}, FULL};
    tbl[3]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,
                64'hFFFFFFFF_FFFFFFF1, FULL};
    tbl[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 64'h1_FFFFFFFE, FULL};
    tbl[5]  = '{1'b1, 1'b0, 32'd9, 32'd0, {32'd9, 32'hFFFFFFFF}, 2};
    tbl[6]  = '{1'b0, 1'b0, 32'd0, 32'h123, 64'd0, SKIP};
    tbl[7]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000,
                64'h40000000_00000000, FULL};
    tbl[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,
                {32'h0, 32'hFFFFFFFF}, FULL};
    tbl[9]  = '{1'b1, 1'b1, 32'd7, 32'hFFFFFFFE,
                {32'd1, 32'hFFFFFFFD}, FULL};
    tbl[10] = '{1'b1, 1'b0, 32'd0, 32'd5, 64'd0, SKIP};
    tbl[11] = '{1'b1, 1'b1, 32'hFFFFFFF7, 32'd0,
                {32'hFFFFFFF7, 32'hFFFFFFFF}, 2};
    tbl[12] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                64'hFFFFFFFE_00000001, FULL};

    md.start_i   = 1'b0;
    md.op_i      = 1'b0;
    md.signed_i  = 1'b0;
    md.opdata1_i = '0;
    md.opdata2_i = '0;
    md.annul_i   = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {md.ready_o, md.busy_o, md.result_o}, 65'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sgn,
             tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom);
      rsg = 1'($urandom);
      ra  = $urandom >> $urandom_range(0, 31);
      rb  = $urandom >> $urandom_range(0, 31);
      if (rop && rb == 0) rb = 32'd3;
      if (rop && rsg && ra == 32'h80000000) ra = 32'd1;
      zc = rop ? (ra == 0) : (ra == 0 || rb == 0);
      run_op($sformatf("rnd%0d", i), rop, rsg, ra, rb,
             model(rop, rsg, ra, rb), zc ? SKIP : FULL);
    end

    // annul in IDLE beats a simultaneous start
    md.start_i = 1'b1;
    md.op_i    = 1'b0;
    md.annul_i = 1'b1;
    @(negedge clk);
    check("annul_vs_start", {63'd0, md.busy_o, md.ready_o}, 65'd0);
    md.annul_i = 1'b0;
    md.start_i = 1'b0;
    @(negedge clk);

    // annul at RUN cycle 10
    md.start_i   = 1'b1;
    md.op_i      = 1'b1;
    md.signed_i  = 1'b0;
    md.opdata1_i = 32'd1000;
    md.opdata2_i = 32'd3;
    repeat (10) @(negedge clk);
    md.annul_i = 1'b1;
    md.start_i = 1'b0;
    @(negedge clk);
    check("annul_idle", {63'd0, md.busy_o, md.ready_o}, 65'd0);
    md.annul_i = 1'b0;
    run_op("annul_restart", 1'b1, 1'b0, 32'd20, 32'd4,
           {32'd0, 32'd5}, FULL);

    // async reset pulsed mid-RUN
    md.start_i   = 1'b1;
    md.op_i      = 1'b1;
    md.signed_i  = 1'b0;
    md.opdata1_i = 32'd1000;
    md.opdata2_i = 32'd3;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    md.start_i = 1'b0;
    #1;
    check("rst_mid_run", {md.ready_o, md.busy_o, md.result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("rst_restart", 1'b1, 1'b0, 32'd20, 32'd4,
           {32'd0, 32'd5}, FULL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
